// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single data RAM between the core memory stage and
// the debug/loader master. The core has priority. A starvation counter bounds
// how long debug can be held off. A lock mode gives debug exclusive bursts.
// Read data has one cycle of latency and is routed back to the master that
// issued the read.
module dram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_op,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [2:0]  dbg_op,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic        dbg_lock,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,

    output logic        ram_wen_n,
    output logic [2:0]  ram_op,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {ARB, LOCK} mode_t;
    typedef enum logic {OWN_CORE, OWN_DBG} owner_t;

    mode_t      mode_q;
    logic [3:0] starve_cnt;
    logic       rd_pend_q;
    owner_t     rd_owner_q;

    logic       core_gnt;
    logic       dbg_win;

    // Grant decision from registered mode/counter and the current requests.
    // Reset forces no grant so the RAM sees no write while rst is high.
    always_comb begin
        dbg_win  = 1'b0;
        core_gnt = 1'b0;
        if (!rst) begin
            if (mode_q == LOCK) begin
                dbg_win = dbg_req;
            end else begin
                dbg_win  = dbg_req && ((starve_cnt >= LIMIT) || !core_req);
                core_gnt = core_req && !dbg_win;
            end
        end
    end

    assign dbg_gnt    = dbg_win;
    assign core_stall = core_req & ~core_gnt & ~rst;

    // RAM port mux. With no grant, the core fields are presented as a read
    // that nobody waits for.
    always_comb begin
        ram_wen_n = 1'b1;
        ram_op    = core_op;
        ram_addr  = core_addr;
        ram_din   = core_wdata;
        if (dbg_win) begin
            ram_wen_n = ~dbg_we;
            ram_op    = dbg_op;
            ram_addr  = dbg_addr;
            ram_din   = dbg_wdata;
        end else if (core_gnt) begin
            ram_wen_n = ~core_we;
        end
    end

    // Return path: both masters see the RAM data, and rvalid selects the owner.
    assign core_rvalid = rd_pend_q & (rd_owner_q == OWN_CORE);
    assign dbg_rvalid  = rd_pend_q & (rd_owner_q == OWN_DBG);
    assign core_rdata  = ram_dout;
    assign dbg_rdata   = ram_dout;

    // Mode FSM, starvation counter and read-owner tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= ARB;
            starve_cnt <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CORE;
        end else begin
            case (mode_q)
                ARB:     if (dbg_win && dbg_lock) mode_q <= LOCK;
                LOCK:    if (!dbg_lock) mode_q <= ARB;
                default: mode_q <= ARB;
            endcase

            if (dbg_win || !dbg_req)
                starve_cnt <= '0;
            else if (core_gnt && (starve_cnt != 4'hF))
                starve_cnt <= starve_cnt + 4'd1;

            rd_pend_q  <= (dbg_win && !dbg_we) || (core_gnt && !core_we);
            rd_owner_q <= dbg_win ? OWN_DBG : OWN_CORE;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Testbench for dram_arbiter. Two instances (STARVE_LIMIT 4 and 0) share the
// same stimulus. Each instance has its own RAM model. A rule-level reference
// model per instance predicts grants, the RAM port and the read return.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
    logic [2:0]  core_op, dbg_op;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;

    logic        stall [2];
    logic        crv   [2];
    logic [31:0] crd   [2];
    logic        dgnt  [2];
    logic        drv   [2];
    logic [31:0] drd   [2];
    logic        wen_n [2];
    logic [2:0]  rop   [2];
    logic [31:0] radr  [2];
    logic [31:0] rdin  [2];
    logic [31:0] rdout [2];

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          lim [2] = '{4, 0};
    bit          m_lock [2];
    int          m_cnt [2];
    bit          m_pend [2];
    bit          m_own_dbg [2];
    logic [31:0] m_data [2];
    logic [31:0] shadow [2][256];
    bit          e_dg [2];
    bit          e_cg [2];

    always #5 clk = ~clk;

    dram_arbiter #(.STARVE_LIMIT(4)) u0 (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_op(core_op),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(stall[0]), .core_rvalid(crv[0]), .core_rdata(crd[0]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_op(dbg_op),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
        .dbg_gnt(dgnt[0]), .dbg_rvalid(drv[0]), .dbg_rdata(drd[0]),
        .ram_wen_n(wen_n[0]), .ram_op(rop[0]), .ram_addr(radr[0]),
        .ram_din(rdin[0]), .ram_dout(rdout[0])
    );

    dram_arbiter #(.STARVE_LIMIT(0)) u1 (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_op(core_op),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(stall[1]), .core_rvalid(crv[1]), .core_rdata(crd[1]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_op(dbg_op),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
        .dbg_gnt(dgnt[1]), .dbg_rvalid(drv[1]), .dbg_rdata(drd[1]),
        .ram_wen_n(wen_n[1]), .ram_op(rop[1]), .ram_addr(radr[1]),
        .ram_din(rdin[1]), .ram_dout(rdout[1])
    );

    // synchronous RAM models, one-cycle read latency
    always @(posedge clk) begin
        if (!wen_n[0]) mem0[radr[0][9:2]] <= rdin[0];
        rdout[0] <= mem0[radr[0][9:2]];
    end
    always @(posedge clk) begin
        if (!wen_n[1]) mem1[radr[1][9:2]] <= rdin[1];
        rdout[1] <= mem1[radr[1][9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lock[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_own_dbg[i] = 0;
            e_dg[i] = 0; e_cg[i] = 0;
        end
    endtask

    // Let the combinational outputs settle, then check them against the rules.
    task automatic settle_check();
        #1;
        for (int i = 0; i < 2; i++) begin
            bit granted, w;
            if (m_lock[i]) begin
                e_dg[i] = dbg_req;
                e_cg[i] = 0;
            end else begin
                e_dg[i] = dbg_req && ((m_cnt[i] >= lim[i]) || !core_req);
                e_cg[i] = core_req && !e_dg[i];
            end
            granted = e_dg[i] || e_cg[i];
            w = e_dg[i] ? dbg_we : core_we;
            chk($sformatf("dbg_gnt[%0d]", i), 32'(dgnt[i]), 32'(e_dg[i]));
            chk($sformatf("core_stall[%0d]", i), 32'(stall[i]), 32'(core_req && !e_cg[i]));
            chk($sformatf("ram_wen_n[%0d]", i), 32'(wen_n[i]), 32'(!(granted && w)));
            chk($sformatf("ram_addr[%0d]", i), radr[i], e_dg[i] ? dbg_addr : core_addr);
            chk($sformatf("ram_op[%0d]", i), 32'(rop[i]), 32'(e_dg[i] ? dbg_op : core_op));
            chk($sformatf("ram_din[%0d]", i), rdin[i], e_dg[i] ? dbg_wdata : core_wdata);
            chk($sformatf("core_rvalid[%0d]", i), 32'(crv[i]), 32'(m_pend[i] && !m_own_dbg[i]));
            chk($sformatf("dbg_rvalid[%0d]", i), 32'(drv[i]), 32'(m_pend[i] && m_own_dbg[i]));
            if (m_pend[i]) begin
                if (m_own_dbg[i]) chk($sformatf("dbg_rdata[%0d]", i), drd[i], m_data[i]);
                else              chk($sformatf("core_rdata[%0d]", i), crd[i], m_data[i]);
            end
        end
    endtask

    // Clock edge, then advance the model with the inputs that were applied.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            bit granted, w;
            logic [31:0] a, d;
            granted = e_dg[i] || e_cg[i];
            w = e_dg[i] ? dbg_we : core_we;
            a = e_dg[i] ? dbg_addr : core_addr;
            d = e_dg[i] ? dbg_wdata : core_wdata;
            if (granted && w) shadow[i][a[9:2]] = d;
            m_pend[i] = granted && !w;
            m_own_dbg[i] = e_dg[i];
            if (m_pend[i]) m_data[i] = shadow[i][a[9:2]];
            if (e_dg[i] || !dbg_req) m_cnt[i] = 0;
            else if (e_cg[i] && m_cnt[i] < 15) m_cnt[i] = m_cnt[i] + 1;
            if (!m_lock[i] && e_dg[i] && dbg_lock) m_lock[i] = 1;
            else if (m_lock[i] && !dbg_lock) m_lock[i] = 0;
        end
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0;
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    // Assert reset mid-cycle with the current inputs, check the forced
    // outputs, then release with the masters idle.
    task automatic do_reset();
        #3;
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_dbg_gnt[%0d]", i), 32'(dgnt[i]), 32'd0);
            chk($sformatf("rst_core_stall[%0d]", i), 32'(stall[i]), 32'd0);
            chk($sformatf("rst_wen_n[%0d]", i), 32'(wen_n[i]), 32'd1);
            chk($sformatf("rst_core_rvalid[%0d]", i), 32'(crv[i]), 32'd0);
            chk($sformatf("rst_dbg_rvalid[%0d]", i), 32'(drv[i]), 32'd0);
        end
        model_reset();
        idle();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        idle();
        core_op = 3'd2; dbg_op = 3'd2;
        core_addr = '0; core_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0; mem1[i] = '0; shadow[0][i] = '0; shadow[1][i] = '0;
        end
        model_reset();
        // reset values with both masters requesting
        core_req = 1; dbg_req = 1; dbg_we = 1;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("init_dbg_gnt[%0d]", i), 32'(dgnt[i]), 32'd0);
            chk($sformatf("init_core_stall[%0d]", i), 32'(stall[i]), 32'd0);
            chk($sformatf("init_wen_n[%0d]", i), 32'(wen_n[i]), 32'd1);
            chk($sformatf("init_rvalid[%0d]", i), 32'(crv[i] | drv[i]), 32'd0);
        end
        idle();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // core-only store then load
        core_req = 1; core_we = 1; core_addr = 32'h100; core_wdata = 32'hDEADBEEF; core_op = 3'd2;
        step();
        core_we = 0; core_wdata = 32'h0;
        step();
        chk("core_load_rvalid", 32'(crv[0]), 32'd1);
        chk("core_load_data", crd[0], 32'hDEADBEEF);
        idle();
        step();

        // contention: both reading continuously
        core_req = 1; core_addr = 32'h100; dbg_req = 1; dbg_addr = 32'h104; dbg_op = 3'd1;
        for (int j = 0; j < 10; j++) begin
            settle_check();
            chk("contend_pattern", 32'(dgnt[0]), (j == 4 || j == 9) ? 32'd1 : 32'd0);
            chk("contend_limit0", 32'(dgnt[1]), 32'd1);
            tick();
        end

        // lock burst of 8 debug writes, core requesting throughout
        begin
            int k = 0;
            int guard = 0;
            dbg_lock = 1; dbg_we = 1; dbg_req = 1;
            while (k < 8 && guard < 40) begin
                dbg_addr = 32'h300 + 32'(k * 4);
                dbg_wdata = 32'hA5A50000 + 32'(k);
                settle_check();
                tick();
                if (e_dg[0]) k++;
                guard++;
            end
            chk("burst_words", 32'(k), 32'd8);
        end
        dbg_lock = 0; dbg_req = 0; dbg_we = 0;
        settle_check();
        chk("lock_fall_stall", 32'(stall[0]), 32'd1);
        tick();
        settle_check();
        chk("post_lock_core_gnt", 32'(stall[0]), 32'd0);
        tick();

        // interleaved reads of 0x200 (core) and 0x204 (debug)
        idle();
        core_req = 1; core_we = 1; core_addr = 32'h200; core_wdata = 32'h11112222;
        step();
        core_addr = 32'h204; core_wdata = 32'h33334444;
        step();
        core_we = 0; core_addr = 32'h200;
        step();
        chk("il_core_rvalid", 32'(crv[0]), 32'd1);
        chk("il_core_data", crd[0], 32'h11112222);
        chk("il_no_dbg_rvalid", 32'(drv[0]), 32'd0);
        core_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h204;
        step();
        chk("il_dbg_rvalid", 32'(drv[0]), 32'd1);
        chk("il_dbg_data", drd[0], 32'h33334444);
        chk("il_no_core_rvalid", 32'(crv[0]), 32'd0);
        idle();
        step();

        // reset during lock with a debug read pending
        dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = 32'h300;
        step();
        core_req = 1;
        do_reset();
        core_req = 1; dbg_req = 1; dbg_lock = 0; core_addr = 32'h200; dbg_addr = 32'h204;
        settle_check();
        chk("post_reset_arb", 32'(stall[0]), 32'd0);
        tick();

        // STARVE_LIMIT=0: debug wins every cycle, core gets in once debug drops
        for (int j = 0; j < 4; j++) begin
            settle_check();
            chk("lim0_dbg_wins", 32'(dgnt[1]), 32'd1);
            chk("lim0_core_stall", 32'(stall[1]), 32'd1);
            tick();
        end
        dbg_req = 0;
        settle_check();
        chk("lim0_core_gnt", 32'(stall[1]), 32'd0);
        tick();

        // randomized traffic
        for (int j = 0; j < 400; j++) begin
            core_req   = 1'($urandom_range(0, 1));
            core_we    = 1'($urandom_range(0, 1));
            core_op    = 3'($urandom);
            core_addr  = $urandom();
            core_wdata = $urandom();
            dbg_req    = 1'($urandom_range(0, 1));
            dbg_we     = 1'($urandom_range(0, 1));
            dbg_op     = 3'($urandom);
            dbg_addr   = $urandom();
            dbg_wdata  = $urandom();
            dbg_lock   = ($urandom_range(0, 3) == 0);
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
